// File: rtl/fifo_access_ctrl.sv
// Arbitrated access controller for a flag-less FIFO_buffer: round-robin producer writes,
// single-consumer read strobes, and occupancy tracking so the FIFO never over/underflows.

module fifo_access_lane #(
    parameter int DATA_W = 8
) (
    input  logic              sel,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    assign dout = sel ? din : '0;
endmodule

module fifo_access_ctrl #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int RD_LAT = 1,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic                    fifo_wr,
    output logic [DATA_W-1:0]       fifo_din,
    input  logic                    rd_req,
    output logic                    rd_ack,
    output logic                    fifo_rd,
    output logic                    rd_valid,
    output logic [CW-1:0]           count,
    output logic                    full,
    output logic                    empty
);
    logic [PW-1:0]                  rr_ptr;
    logic [PW-1:0]                  sel_idx;
    logic [PW-1:0]                  nxt_ptr;
    logic [PW-1:0]                  idx;
    logic                           found;
    logic                           wr_ok;
    logic [N_REQ-1:0][DATA_W-1:0]   lane_dat;
    logic [DATA_W-1:0]              sel_dat;
    logic [RD_LAT:0]                vld_pipe;

    assign wr_ok = (count < CW'(DEPTH));

    // Search starts at rr_ptr so the most recently served producer goes last.
    always_comb begin
        gnt     = '0;
        sel_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = PW'((int'(rr_ptr) + k) % N_REQ);
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                sel_idx      = idx;
            end
        end
        if (!rst || !wr_ok)
            gnt = '0;
    end

    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        fifo_access_lane #(.DATA_W(DATA_W)) u_lane (
            .sel  (gnt[i]),
            .din  (wdata[i*DATA_W +: DATA_W]),
            .dout (lane_dat[i])
        );
    end

    always_comb begin
        sel_dat = '0;
        for (int k = 0; k < N_REQ; k++)
            sel_dat = sel_dat | lane_dat[k];
    end

    assign nxt_ptr = (sel_idx == PW'(N_REQ - 1)) ? '0 : sel_idx + 1'b1;

    // Both sides look at the pre-edge count, so a same-cycle read never frees room for a write.
    assign rd_ack = rst & rd_req & (count != '0);
    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);

    // vld_pipe[0] is the read strobe itself; the tail marks Data_out valid.
    assign fifo_rd  = vld_pipe[0];
    assign rd_valid = vld_pipe[RD_LAT];

    always_ff @(posedge clk) begin
        if (!rst) begin
            fifo_wr  <= 1'b0;
            fifo_din <= '0;
            rr_ptr   <= '0;
            count    <= '0;
            vld_pipe <= '0;
        end else begin
            fifo_wr  <= |gnt;
            if (|gnt) begin
                fifo_din <= sel_dat;
                rr_ptr   <= nxt_ptr;
            end
            vld_pipe <= {vld_pipe[RD_LAT-1:0], rd_ack};
            count    <= count + CW'(|gnt) - CW'(rd_ack);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            assert ($onehot0(gnt));
            assert ((gnt & ~req) == '0);
            assert (count <= CW'(DEPTH));
        end
    end
endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Directed bench for fifo_access_ctrl with a write/read scoreboard and a small FIFO data model.

module tb_fifo_access_ctrl;
    localparam int N_REQ = 4, DATA_W = 8, DEPTH = 16, RD_LAT = 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic                    clk = 1'b1;
    logic                    rst;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] wdata;
    logic [N_REQ-1:0]        gnt;
    logic                    fifo_wr;
    logic [DATA_W-1:0]       fifo_din;
    logic                    rd_req, rd_ack, fifo_rd, rd_valid;
    logic [CW-1:0]           count;
    logic                    full, empty;

    int n_cmp = 0, n_err = 0;
    int cyc = 0, mcount = 0, n_rdv = 0, base = 0;
    bit mon_on = 1'b0;
    logic [DATA_W-1:0] exp_wq[$], exp_rq[$], model_q[$];
    logic [DATA_W-1:0] dout_m = '0;
    int tq[$];

    always #5 clk = ~clk;

    fifo_access_ctrl #(.N_REQ(N_REQ), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata), .gnt(gnt),
        .fifo_wr(fifo_wr), .fifo_din(fifo_din), .rd_req(rd_req), .rd_ack(rd_ack),
        .fifo_rd(fifo_rd), .rd_valid(rd_valid), .count(count), .full(full), .empty(empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Mid-cycle monitor: check what the DUT shows now, then predict the coming edge.
    task automatic mon();
        if (mon_on) begin
            if (fifo_wr) begin
                chk("fifo_wr_expected", 32'(exp_wq.size() != 0), 1);
                if (exp_wq.size() != 0) chk("fifo_din", 32'(fifo_din), 32'(exp_wq.pop_front()));
            end
            if (rd_valid) begin
                n_rdv++;
                chk("rd_valid_expected", 32'(tq.size() != 0), 1);
                if (tq.size() != 0) chk("rd_valid_cycle", 32'(cyc), 32'(tq.pop_front()));
                if (exp_rq.size() != 0) chk("rd_data", 32'(dout_m), 32'(exp_rq.pop_front()));
            end
            chk("count", 32'(count), 32'(mcount));
            chk("full", 32'(full), 32'(mcount == DEPTH));
            chk("empty", 32'(empty), 32'(mcount == 0));
            chk("rd_ack", 32'(rd_ack), 32'(rd_req && rst && mcount != 0));
            if (!rst || mcount == DEPTH) chk("gnt_blocked", 32'(gnt), 0);
            chk("gnt_onehot", 32'($onehot0(gnt)), 1);
            chk("gnt_req", 32'(gnt & ~req), 0);
        end
        if (!rst) begin
            exp_wq.delete(); exp_rq.delete(); model_q.delete(); tq.delete();
            mcount = 0;
        end else begin
            if (fifo_wr) model_q.push_back(fifo_din);
            if (fifo_rd && model_q.size() != 0) dout_m = model_q.pop_front();
            for (int i = 0; i < N_REQ; i++)
                if (gnt[i]) begin
                    exp_wq.push_back(wdata[i*DATA_W +: DATA_W]);
                    exp_rq.push_back(wdata[i*DATA_W +: DATA_W]);
                end
            if (rd_ack) tq.push_back(cyc + 1 + RD_LAT);
            mcount = mcount + ((gnt != '0) ? 1 : 0) - (rd_ack ? 1 : 0);
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        logic [3:0] g;
        // 1: reset with all producers requesting
        rst = 1'b0; req = 4'hf; rd_req = 1'b0;
        wdata = {8'h13, 8'h12, 8'h11, 8'h10};
        #1 chk("rst_gnt", 32'(gnt), 0);
        tick(); tick();
        mon_on = 1'b1;
        #1;
        chk("rst_gnt2", 32'(gnt), 0);
        chk("rst_fifo_wr", 32'(fifo_wr), 0);
        chk("rst_fifo_rd", 32'(fifo_rd), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);

        // 2: round robin
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            g = 4'b0001 << (k % 4);
            chk("rr_gnt", 32'(gnt), 32'(g));
            if (k > 0) begin
                chk("rr_din", 32'(fifo_din), 32'(8'h10 + (k - 1) % 4));
                chk("rr_wr", 32'(fifo_wr), 1);
            end
            tick();
        end
        req = '0;
        #1 chk("rr_din_last", 32'(fifo_din), 32'h10);
        chk("rr_wr_last", 32'(fifo_wr), 1);
        tick();
        #1 chk("rr_wr_idle", 32'(fifo_wr), 0);
        chk("rr_count", 32'(count), 5);

        // 3: fill with a lone requester
        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            wdata[16 +: 8] = 8'(c);
            #1 chk("fill_gnt", 32'(gnt), (c < 16) ? 32'h4 : 32'h0);
            if (c >= 17) chk("fill_wr_low", 32'(fifo_wr), 0);
            tick();
        end
        req = '0;
        #1 chk("fill_count", 32'(count), 16);
        chk("fill_full", 32'(full), 1);
        chk("fill_empty", 32'(empty), 0);

        // 4: drain from full
        base = n_rdv;
        rd_req = 1'b1;
        for (int c = 0; c < 18; c++) begin
            #1 chk("drain_ack", 32'(rd_ack), 32'(c < 16));
            tick();
        end
        rd_req = 1'b0;
        tick(); tick();
        chk("drain_pulses", 32'(n_rdv - base), 16);
        chk("drain_empty", 32'(empty), 1);
        chk("drain_count", 32'(count), 0);

        // 5: simultaneous write and read at count 5
        req = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            wdata[7:0] = 8'(8'h50 + c);
            #1 chk("pre5_gnt", 32'(gnt), 1);
            tick();
        end
        req = '0;
        #1 chk("pre5_count", 32'(count), 5);
        req = 4'b0001; rd_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            wdata[7:0] = 8'(8'h60 + c);
            #1 chk("sim_gnt", 32'(gnt), 1);
            chk("sim_ack", 32'(rd_ack), 1);
            tick();
        end
        req = '0; rd_req = 1'b0;
        #1 chk("sim_count", 32'(count), 5);
        tick(); tick();

        // 6: reset while writing and reading at count 7
        req = 4'b0001;
        for (int c = 0; c < 2; c++) begin
            wdata[7:0] = 8'(8'h70 + c);
            #1 chk("pre6_gnt", 32'(gnt), 1);
            tick();
        end
        rd_req = 1'b1; wdata[7:0] = 8'h72;
        #1 chk("pre6_count", 32'(count), 7);
        tick();
        rst = 1'b0;
        #1 chk("mid_rst_gnt", 32'(gnt), 0);
        chk("mid_rst_ack", 32'(rd_ack), 0);
        tick();
        rst = 1'b1; req = '0; rd_req = 1'b0;
        #1 chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_empty", 32'(empty), 1);
        chk("mid_rst_wr", 32'(fifo_wr), 0);
        chk("mid_rst_rd", 32'(fifo_rd), 0);
        chk("mid_rst_rdv", 32'(rd_valid), 0);
        req = 4'hf;
        wdata = {8'h83, 8'h82, 8'h81, 8'h80};
        #1 chk("post_rst_gnt", 32'(gnt), 1);
        tick();
        req = '0;
        repeat (4) tick();
        chk("pending_rd_valid", 32'(tq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
